// File: rtl/reg_share_arb_pkg.sv
// Shared definitions for the reg_share_arb slice.
//   state_t      : arbiter FSM encoding (IDLE = 0, BUSY = 1)
//   DEF_N        : default number of requesters
//   DEF_W        : default shared register width
//   DEF_MAX_HOLD : default load cycles per grant before forced rotation
//   HOLD_W       : hold counter width (covers MAX_HOLD up to 15)
package reg_share_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;
  localparam int HOLD_W       = 4;

endpackage

// File: rtl/reg_share_arb_dff_en.sv
// W-bit register with synchronous active-high reset and load enable.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, clears Q
//   EN  : load enable, Q <= D when high
//   D   : data in
//   Q   : registered data out
module dff_en
  import reg_share_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter granting N requesters write access to one shared
// W-bit register, with forced rotation after MAX_HOLD consecutive loads.
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   REQ   : per-requester level request
//   WDATA : flattened write data, slice i at [i*W +: W]
//   GNT   : registered one-hot grant, zero when idle
//   OWNER : index of the granted requester, zero when idle
//   Q     : shared register contents
//   LOAD  : high the cycle after Q was written
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N*W-1:0]       WDATA,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] OWNER,
  output logic [W-1:0]         Q,
  output logic                 LOAD
);

  localparam int LG = $clog2(N);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t            state, state_n;
  logic [N-1:0]      gnt_n;
  logic [LG-1:0]     owner_n;
  logic [LG-1:0]     ptr, ptr_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [LG-1:0]     pick, cand;
  logic              found;
  logic              take;
  logic              do_load;
  logic [W-1:0]      wsel;

  // First requester at or after ptr (mod N). While BUSY the current owner
  // is excluded: on release it is not requesting anyway, and on forced
  // rotation it must not be re-picked. ptr is always owner+1 while BUSY.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + LG'(k);
      if (!found && REQ[cand] && !(state == BUSY && cand == OWNER)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (OWNER == LG'(i)) begin
        wsel = WDATA[i*W +: W];
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    owner_n = OWNER;
    ptr_n   = ptr;
    hold_n  = hold;
    do_load = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        take = found;
      end
      BUSY: begin
        if (REQ[OWNER]) begin
          do_load = 1'b1;
          if (hold + HOLD_W'(1) == HOLD_LIM) begin
            // Limit reached: hand over if anyone else waits, else restart.
            hold_n = '0;
            take   = found;
          end else begin
            hold_n = hold + HOLD_W'(1);
          end
        end else begin
          hold_n = '0;
          if (found) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            owner_n = '0;
          end
        end
      end
    endcase
    if (take) begin
      state_n     = BUSY;
      gnt_n       = '0;
      gnt_n[pick] = 1'b1;
      owner_n     = pick;
      ptr_n       = pick + LG'(1);
      hold_n      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      GNT   <= '0;
      OWNER <= '0;
      ptr   <= '0;
      hold  <= '0;
      LOAD  <= 1'b0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      OWNER <= owner_n;
      ptr   <= ptr_n;
      hold  <= hold_n;
      LOAD  <= do_load;
    end
  end

  dff_en #(.W(W)) u_q (
    .CLK (CLK),
    .RST (RST),
    .EN  (do_load),
    .D   (wsel),
    .Q   (Q)
  );

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the register (power of two, 2..8).
REQ-002 Parameter W, default 8, width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive load cycles per grant before forced rotation (1..15).
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-006 REQ  input  N  per-requester access request, level-sensitive.
REQ-007 WDATA  input  N*W  flattened write data; slice i is bits [i*W+W-1 : i*W].
REQ-008 GNT  output  N  registered one-hot grant; all-zero when idle.
REQ-009 OWNER  output  log2(N)  index of granted requester; 0 when idle.
REQ-010 Q  output  W  shared register contents.
REQ-011 LOAD  output  1  registered pulse, high the cycle after Q was updated.

Function
REQ-012 FSM states: IDLE (no grant) and BUSY (exactly one GNT bit high).
REQ-013 IDLE -> BUSY: when any REQ bit is high at an edge, GNT sets on that edge to the first requesting index at or after PTR, searching upward modulo N (1-cycle latency from REQ to GNT).
REQ-014 PTR: after any grant to index i, PTR = (i+1) mod N.
REQ-015 Load: on each edge where GNT[i] and REQ[i] are both high, Q <= WDATA slice i and LOAD = 1 on the following cycle; otherwise Q holds and LOAD = 0.
REQ-016 Hold counter: increments on each load edge, clears on any grant change.
REQ-017 Release: if REQ[owner] is low at an edge, the grant moves to the next requester per REQ-013 on that same edge; if none is requesting, the FSM enters IDLE with GNT = 0. There is no idle bubble between owners.
REQ-018 Forced rotation: on the edge where the hold counter reaches MAX_HOLD, the grant moves to the next requesting index other than the owner. If no other requester is active, the owner keeps the grant and the counter restarts at 0.
REQ-019 Under continuous contention, no requester waits more than (N-1)*MAX_HOLD+1 cycles from REQ high to GNT.
REQ-020 A REQ bit raised by a non-owner while BUSY is not granted until release or rotation.
REQ-021 At most one GNT bit is high in any cycle. OWNER always equals the index of that bit.
REQ-022 No requester's write to Q occurs without its GNT bit high at the same edge.

Reset
REQ-023 RST high at an edge forces state IDLE, GNT = 0, OWNER = 0, Q = 0, LOAD = 0, PTR = 0, hold counter = 0, regardless of REQ or WDATA.
REQ-024 Reset during BUSY aborts the grant with no load on that edge. Arbitration resumes on the first edge with RST low.

Structure
REQ-025 A shared package holds the state encoding constants (IDLE = 0, BUSY = 1) and the default values of N, W and MAX_HOLD.
REQ-026 Q is held in one sub-module, dff_en: a W-bit register with CLK, synchronous active-high RST, enable and D inputs, instantiated once.
REQ-027 Arbitration, PTR, hold counter and FSM live in reg_share_arb; all outputs are driven directly from registers.

Verification
REQ-028 Reset: RST = 1 for 2 cycles with REQ = 4'b1111 -> GNT = 0, Q = 0, LOAD = 0 throughout. Release RST -> GNT = 4'b0001 one edge later.
REQ-029 Single requester: REQ = 4'b0100, WDATA slice 2 = 8'hA5 -> GNT = 4'b0100 after 1 edge, Q = 8'hA5 next edge, LOAD = 1 the cycle after. Drop REQ -> GNT = 0 next edge.
REQ-030 Round-robin: REQ = 4'b1111 held with MAX_HOLD = 4 -> GNT sequence 0001, 0010, 0100, 1000, 0001, each held for exactly 4 load cycles, with no zero-GNT gap.
REQ-031 Lone owner at limit: REQ = 4'b0010 for 12 cycles -> GNT stays 4'b0010 and Q updates every edge.
REQ-032 Early release: owner 0 drops REQ after 2 loads while REQ[3] is high -> GNT = 4'b1000 on the release edge and PTR = 0.
REQ-033 Reset mid-grant: RST pulsed while GNT = 4'b0100 and Q = 8'h3C -> Q = 0 and GNT = 0 next edge. With REQ = 4'b0110 afterwards, GNT = 4'b0010.
